dac_spi_receiver: RTL and testbench

- Synthesizable model of the dual-channel 12-bit SPI DAC driven by the laser beta's mapped IO (dac_mosi/dac_sclk/dac_csn/dac_latchn).
- Oversamples the SPI lines in the system clock domain, deframes 16-bit command words, and holds per-channel input registers.
- Transfers the input registers to the outputs on a latch strobe.
- Used as the receiving end in simulation benches and as an on-FPGA loopback/debug monitor for the galvo X/Y channels.

---
 rtl/dac_spi_receiver_if.sv | 22 ++
 rtl/dac_spi_receiver.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dac_spi_receiver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_receiver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dac_spi_if                                                    |
// | Purpose  : Groups the four mapped-IO lines of the dual-channel SPI DAC    |
// |            (serial clock, serial data, frame select, latch strobe).      |
// | Ports    : sclk   - SPI clock, data sampled on its rising edge           |
// |            mosi   - serial data, MSB first                               |
// |            csn    - frame select, active low                             |
// |            latchn - latch strobe, active low, falling edge transfers     |
// | Modports : master drives the lines, slave (the DAC model) receives them. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface dac_spi_if;
   logic sclk;
   logic mosi;
   logic csn;
   logic latchn;

   modport master (output sclk, output mosi, output csn, output latchn);
   modport slave  (input  sclk, input  mosi, input  csn, input  latchn);
endinterface
`default_nettype wire

// File: rtl/dac_spi_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dac_spi_receiver                                              |
// | Purpose  : Receiving end of the dual-channel 12-bit SPI DAC. Oversamples  |
// |            the SPI lines in the clk domain, deframes DATA_BITS+4 bit      |
// |            command words into per-channel input registers and transfers  |
// |            them to the outputs on a latch strobe falling edge.           |
// | Ports    : clk        - system clock                                     |
// |            reset      - asynchronous, active-high reset                  |
// |            spi        - dac_spi_if.slave (sclk/mosi/csn/latchn)          |
// |            dac_a/b    - channel output codes (0 while shut down)         |
// |            shdn_a/b   - channel shut-down flags                          |
// |            word_valid - one-cycle pulse when a good word is committed    |
// |            frame_err  - one-cycle pulse on a malformed frame             |
// | Options  : DAC_RX_AUTOLATCH_EN - when defined, latchn is ignored and a    |
// |            committed word updates its output in the word_valid cycle.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dac_spi_receiver #(
   parameter int DATA_BITS   = 12,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   dac_spi_if.slave                  spi,
   output logic [DATA_BITS-1:0]      dac_a,
   output logic [DATA_BITS-1:0]      dac_b,
   output logic                      shdn_a,
   output logic                      shdn_b,
   output logic                      word_valid,
   output logic                      frame_err
);

   localparam int         WORD_BITS = DATA_BITS + 4;
   localparam logic [4:0] CNT_FULL  = 5'(WORD_BITS);
   // One past a full word marks "too many bits" without wrapping.
   localparam logic [4:0] CNT_SAT   = 5'(WORD_BITS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizers plus previous-value flops for edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] csn_sync;
   logic                   sclk_prev;
   logic                   csn_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         csn_sync  <= '1;
         sclk_prev <= 1'b0;
         csn_prev  <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0],  spi.csn};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         csn_prev  <= csn_sync[SYNC_STAGES-1];
      end
   end

   logic sclk_s;
   logic mosi_s;
   logic csn_s;
   logic sclk_rise;
   logic csn_fall;
   logic csn_rise;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_prev;
   assign csn_fall  = ~csn_s  &  csn_prev;
   assign csn_rise  =  csn_s  & ~csn_prev;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t state_q;
   state_t state_d;
   logic   clr_en;
   logic   shift_en;
   logic   commit;
   logic   err;

   logic [WORD_BITS-1:0] shreg;
   logic [4:0]           bit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      clr_en   = 1'b0;
      shift_en = 1'b0;
      commit   = 1'b0;
      err      = 1'b0;
      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               clr_en  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               if (bit_cnt == CNT_FULL) begin
                  state_d = COMMIT;
               end else begin
                  err     = 1'b1;
                  state_d = IDLE;
               end
            end else if (sclk_rise && !csn_s) begin
               shift_en = 1'b1;
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shift register and bit counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (clr_en) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (shift_en) begin
         shreg <= {shreg[WORD_BITS-2:0], mosi_s};
         if (bit_cnt != CNT_SAT) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   // Command word fields
   logic                 word_sel;
   logic                 word_on;
   logic [DATA_BITS-1:0] word_code;

   assign word_sel  = shreg[WORD_BITS-1];
   assign word_on   = shreg[DATA_BITS];
   assign word_code = shreg[DATA_BITS-1:0];

   // ------------------------------------------------------------------
   // Input registers. The *_d values include the word being committed
   // this cycle so a coincident latch sees the new data.
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] in_a_code;
   logic [DATA_BITS-1:0] in_b_code;
   logic                 in_a_on;
   logic                 in_b_on;
   logic [DATA_BITS-1:0] in_a_code_d;
   logic [DATA_BITS-1:0] in_b_code_d;
   logic                 in_a_on_d;
   logic                 in_b_on_d;

   always_comb begin
      in_a_code_d = in_a_code;
      in_a_on_d   = in_a_on;
      in_b_code_d = in_b_code;
      in_b_on_d   = in_b_on;
      if (commit) begin
         if (word_sel) begin
            in_b_code_d = word_code;
            in_b_on_d   = word_on;
         end else begin
            in_a_code_d = word_code;
            in_a_on_d   = word_on;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_a_code  <= '0;
         in_a_on    <= 1'b0;
         in_b_code  <= '0;
         in_b_on    <= 1'b0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         in_a_code  <= in_a_code_d;
         in_a_on    <= in_a_on_d;
         in_b_code  <= in_b_code_d;
         in_b_on    <= in_b_on_d;
         word_valid <= commit;
         frame_err  <= err;
      end
   end

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
`ifdef DAC_RX_AUTOLATCH_EN
   // latchn is unused here; the committed channel updates directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dac_a  <= '0;
         dac_b  <= '0;
         shdn_a <= 1'b0;
         shdn_b <= 1'b0;
      end else if (commit) begin
         if (word_sel) begin
            dac_b  <= word_on ? word_code : '0;
            shdn_b <= ~word_on;
         end else begin
            dac_a  <= word_on ? word_code : '0;
            shdn_a <= ~word_on;
         end
      end
   end
`else
   logic [SYNC_STAGES-1:0] latchn_sync;
   logic                   latchn_prev;
   logic                   latch_fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latchn_sync <= '1;
         latchn_prev <= 1'b1;
      end else begin
         latchn_sync <= {latchn_sync[SYNC_STAGES-2:0], spi.latchn};
         latchn_prev <= latchn_sync[SYNC_STAGES-1];
      end
   end

   assign latch_fall = ~latchn_sync[SYNC_STAGES-1] & latchn_prev;

   // A shut-down channel drives a zero code regardless of its stored code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dac_a  <= '0;
         dac_b  <= '0;
         shdn_a <= 1'b0;
         shdn_b <= 1'b0;
      end else if (latch_fall) begin
         dac_a  <= in_a_on_d ? in_a_code_d : '0;
         shdn_a <= ~in_a_on_d;
         dac_b  <= in_b_on_d ? in_b_code_d : '0;
         shdn_b <= ~in_b_on_d;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dac_spi_receiver                                           |
// | Purpose  : Directed self-checking bench for dac_spi_receiver. Inputs are |
// |            driven on the falling clock edge; outputs are sampled there.  |
// |            Define DAC_RX_AUTOLATCH_EN to run the auto-latch sequence.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dac_spi_receiver;

   localparam int DATA_BITS = 12;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [DATA_BITS-1:0] dac_a;
   logic [DATA_BITS-1:0] dac_b;
   logic                 shdn_a;
   logic                 shdn_b;
   logic                 word_valid;
   logic                 frame_err;

   int n_assert = 0;
   int n_fail   = 0;
   int wv_cnt   = 0;
   int fe_cnt   = 0;

   dac_spi_if spi_bus ();

   dac_spi_receiver #(
      .DATA_BITS   (DATA_BITS),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .spi        (spi_bus.slave),
      .dac_a      (dac_a),
      .dac_b      (dac_b),
      .shdn_a     (shdn_a),
      .shdn_b     (shdn_b),
      .word_valid (word_valid),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters
   always @(negedge clk) begin
      if (word_valid) wv_cnt++;
      if (frame_err)  fe_cnt++;
   end

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives csn low and shifts n bits of w, MSB first; csn is left low.
   task automatic shift_bits(input logic [31:0] w, input int n);
      spi_bus.csn = 1'b0;
      wait_n(4);
      for (int i = n - 1; i >= 0; i--) begin
         spi_bus.mosi = w[i];
         spi_bus.sclk = 1'b0;
         wait_n(4);
         spi_bus.sclk = 1'b1;
         wait_n(4);
      end
      spi_bus.sclk = 1'b0;
      wait_n(4);
   endtask

   task automatic send_word(input logic [31:0] w, input int n);
      shift_bits(w, n);
      spi_bus.csn = 1'b1;
      wait_n(8);
   endtask

   task automatic pulse_latch();
      spi_bus.latchn = 1'b0;
      wait_n(4);
      spi_bus.latchn = 1'b1;
      wait_n(4);
   endtask

   initial begin
      int  wv0;
      int  fe0;
      bit  seen;
      reset          = 1'b1;
      spi_bus.sclk   = 1'b0;
      spi_bus.mosi   = 1'b0;
      spi_bus.csn    = 1'b1;
      spi_bus.latchn = 1'b1;
      wait_n(3);
      chk("reset_dac_a", dac_a, 0);
      chk("reset_dac_b", dac_b, 0);
      chk("reset_shdn", {shdn_b, shdn_a}, 0);
      chk("reset_flags", {word_valid, frame_err}, 0);
      reset = 1'b0;
      wait_n(4);

`ifdef DAC_RX_AUTOLATCH_EN
      // Auto-latch: output follows the commit, latchn held high
      shift_bits(32'h9777, 16);
      spi_bus.csn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (word_valid) seen = 1'b1;
      end
      chk("auto_wv_seen", seen, 1);
      chk("auto_dac_b", dac_b, 12'h777);
      chk("auto_shdn_b", shdn_b, 0);
      chk("auto_dac_a", dac_a, 0);
      wait_n(8);
      chk("auto_wv_cnt", wv_cnt, 1);
      chk("auto_fe_cnt", fe_cnt, 0);
`else
      // Single word then latch
      send_word(32'h1ABC, 16);
      chk("w1_wv_cnt", wv_cnt, 1);
      chk("w1_fe_cnt", fe_cnt, 0);
      chk("w1_prelatch_a", dac_a, 0);
      pulse_latch();
      chk("w1_dac_a", dac_a, 12'hABC);
      chk("w1_shdn_a", shdn_a, 0);
      chk("w1_dac_b", dac_b, 0);
      chk("w1_shdn_b", shdn_b, 1);

      // Two channels, one latch updates both together
      send_word(32'h9123, 16);
      send_word(32'h1456, 16);
      chk("w2_prelatch_b", dac_b, 0);
      spi_bus.latchn = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (dac_a != 12'hABC) seen = 1'b1;
      end
      chk("w2_latch_seen", seen, 1);
      chk("w2_dac_a", dac_a, 12'h456);
      chk("w2_dac_b_same_cycle", dac_b, 12'h123);
      spi_bus.latchn = 1'b1;
      wait_n(4);

      // Malformed frames: 15 and 17 bits
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      send_word(32'h0000_7FFF, 15);
      send_word(32'h0001_0FFF, 17);
      chk("bad_fe_cnt", fe_cnt - fe0, 2);
      chk("bad_wv_cnt", wv_cnt - wv0, 0);
      pulse_latch();
      chk("bad_dac_a", dac_a, 12'h456);
      chk("bad_dac_b", dac_b, 12'h123);
      chk("bad_shdn", {shdn_b, shdn_a}, 0);

      // Shutdown then wake channel A
      send_word(32'h0FFF, 16);
      pulse_latch();
      chk("sd_dac_a", dac_a, 0);
      chk("sd_shdn_a", shdn_a, 1);
      send_word(32'h1800, 16);
      pulse_latch();
      chk("wake_dac_a", dac_a, 12'h800);
      chk("wake_shdn_a", shdn_a, 0);

      // Latch edge coincident with COMMIT: forwarded value
      shift_bits(32'h1321, 16);
      spi_bus.csn = 1'b1;
      wait_n(1);
      spi_bus.latchn = 1'b0;
      wait_n(2);
      chk("fwd_before", dac_a, 12'h800);
      wait_n(1);
      chk("fwd_dac_a", dac_a, 12'h321);
      chk("fwd_wv_latency", word_valid, 1);
      wait_n(4);
      spi_bus.latchn = 1'b1;
      wait_n(8);

      // Reset mid-frame after 8 bits
      shift_bits(32'h0000_00A5, 8);
      reset       = 1'b1;
      spi_bus.csn = 1'b1;
      wait_n(3);
      reset = 1'b0;
      wait_n(4);
      chk("mid_rst_dac", {dac_b, dac_a}, 0);
      chk("mid_rst_shdn", {shdn_b, shdn_a}, 0);
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      send_word(32'h1005, 16);
      pulse_latch();
      chk("post_rst_wv", wv_cnt - wv0, 1);
      chk("post_rst_fe", fe_cnt - fe0, 0);
      chk("post_rst_dac_a", dac_a, 12'h005);
      chk("post_rst_shdn_a", shdn_a, 0);
      chk("post_rst_dac_b", dac_b, 0);
      chk("post_rst_shdn_b", shdn_b, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
